// File: rtl/result_collector_if.sv
// Tile-result ingress and coordinate-tagged result egress of the result collector.
// Egress handshake: a word transfers on a clock edge where out_valid && out_ready; while
// out_valid is high and out_ready is low, out_data/out_row/out_col stay unchanged.
interface result_collector_if;
  logic        push11;
  logic        pushedge;
  logic        push22;
  logic [31:0] c11;
  logic [31:0] c12;
  logic [31:0] c21;
  logic [31:0] c22;
  logic [31:0] out_data;
  logic [16:0] out_row;
  logic [16:0] out_col;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output push11, pushedge, push22, c11, c12, c21, c22, out_ready,
    input  out_data, out_row, out_col, out_valid
  );

  modport slave (
    input  push11, pushedge, push22, c11, c12, c21, c22, out_ready,
    output out_data, out_row, out_col, out_valid
  );
endinterface

// File: rtl/result_collector.sv
// Collects 2x2 tile results into a FIFO and streams them out in row-major order,
// tagging each word with its matrix row/column.
module result_collector #(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [16:0]         size,
  result_collector_if.slave   bus,
  output logic                done,
  output logic                overflow,
  output logic                busy,
  output logic [1:0]          state_dbg
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACTIVE  = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_p1;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   free;
  logic [31:0]   mem [DEPTH];
  logic [15:0]   h;
  logic [15:0]   tr;
  logic [15:0]   tc;
  logic [1:0]    e;
  logic [1:0]    n_req;
  logic [1:0]    n_wr;
  logic          fits;
  logic          wr_en;
  logic          pop;
  logic          last_word;

  // Only the highest-priority strobe is serviced; the rest are silently ignored.
  always_comb begin
    n_req = 2'd0;
    if (bus.push11)        n_req = 2'd1;
    else if (bus.pushedge) n_req = 2'd2;
    else if (bus.push22)   n_req = 2'd1;
  end

  // Free space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
  assign free      = (AW+1)'(DEPTH) - occ;
  assign fits      = {{(AW-1){1'b0}}, n_req} <= free;
  assign wr_en     = (state == ACTIVE) && (n_req != 2'd0) && fits;
  assign n_wr      = wr_en ? n_req : 2'd0;
  assign wr_ptr_p1 = wr_ptr + AW'(1);

  assign bus.out_valid = (state == ACTIVE) && (occ != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign last_word     = (e == 2'd3) && (tc == h - 16'd1) && (tr == h - 16'd1);

  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : 32'd0;
  assign bus.out_row  = {tr, e[1]};
  assign bus.out_col  = {tc, e[0]};

  assign done      = (state == DONE_ST);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!bus.push11 && bus.pushedge) begin
        mem[wr_ptr]    <= bus.c12;
        mem[wr_ptr_p1] <= bus.c21;
      end else begin
        mem[wr_ptr] <= bus.push11 ? bus.c11 : bus.c22;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      h        <= '0;
      tr       <= '0;
      tc       <= '0;
      e        <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (size >= 17'd2)) begin
            state    <= ACTIVE;
            h        <= size[16:1];
            tr       <= '0;
            tc       <= '0;
            e        <= '0;
            overflow <= 1'b0;
            // Leftovers from a previous job would get wrong coordinates, so start empty.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
          end
        end
        ACTIVE: begin
          if ((n_req != 2'd0) && !fits) overflow <= 1'b1;
          if (wr_en) wr_ptr <= wr_ptr + AW'(n_req);
          occ <= occ + (AW+1)'(n_wr) - (AW+1)'(pop);
          if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            e      <= e + 2'd1;
            if (e == 2'd3) begin
              if (tc == h - 16'd1) begin
                tc <= '0;
                tr <= tr + 16'd1;
              end else begin
                tc <= tc + 16'd1;
              end
            end
            if (last_word) state <= DONE_ST;
          end
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios plus randomized jobs
// compared cycle by cycle against a queue-based reference model.
module tb_result_collector;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [16:0] size;
  logic        done;
  logic        overflow;
  logic        busy;
  logic [1:0]  state_dbg;

  result_collector_if bus();

  result_collector #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .bus       (bus.slave),
    .done      (done),
    .overflow  (overflow),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and reference model
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int          m_state;   // 0 idle, 1 collecting, 2 done pulse
  int          m_h;
  longint      m_j;       // handshakes completed in the current job
  bit          m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_h     = 0;
    m_j     = 0;
    m_ovf   = 0;
    exp_q.delete();
  endtask

  // Compare outputs mid-cycle, then advance the model across the next rising edge.
  task automatic cycle();
    int     n;
    int     room;
    bit     exp_valid;
    longint tile;
    longint el;
    @(negedge clk);
    exp_valid = (m_state == 1) && (exp_q.size() != 0);
    check("out_valid", bus.out_valid, exp_valid);
    if (exp_valid) begin
      tile = m_j / 4;
      el   = m_j % 4;
      check("out_data", bus.out_data, exp_q[0]);
      check("out_row",  bus.out_row,  2 * (tile / m_h) + el / 2);
      check("out_col",  bus.out_col,  2 * (tile % m_h) + el % 2);
    end
    check("done",     done,     m_state == 2);
    check("busy",     busy,     m_state != 0);
    check("overflow", overflow, m_ovf);
    case (m_state)
      0: if (start && size >= 2) begin
        m_state = 1;
        m_h     = int'(size) / 2;
        m_j     = 0;
        m_ovf   = 0;
        exp_q.delete();
      end
      1: begin
        n    = bus.push11 ? 1 : bus.pushedge ? 2 : bus.push22 ? 1 : 0;
        room = DEPTH - exp_q.size();
        if (n > 0) begin
          if (n <= room) begin
            if (bus.push11) exp_q.push_back(bus.c11);
            else if (bus.pushedge) begin
              exp_q.push_back(bus.c12);
              exp_q.push_back(bus.c21);
            end else exp_q.push_back(bus.c22);
          end else m_ovf = 1;
        end
        if (exp_valid && bus.out_ready) begin
          void'(exp_q.pop_front());
          if (m_j == 4 * longint'(m_h) * m_h - 1) m_state = 2;
          m_j++;
        end
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input bit st, input logic [16:0] sz, input bit p11, input bit pe,
                       input bit p22, input bit rdy);
    start         = st;
    size          = sz;
    bus.push11    = p11;
    bus.pushedge  = pe;
    bus.push22    = p22;
    bus.out_ready = rdy;
    cycle();
    start        = 1'b0;
    bus.push11   = 1'b0;
    bus.pushedge = 1'b0;
    bus.push22   = 1'b0;
  endtask

  task automatic rand_data();
    bus.c11 = $urandom;
    bus.c12 = $urandom;
    bus.c21 = $urandom;
    bus.c22 = $urandom;
  endtask

  task automatic push_tile(input bit rdy);
    rand_data();
    drive(0, 0, 1, 0, 0, rdy);
    drive(0, 0, 0, 1, 0, rdy);
    drive(0, 0, 0, 0, 1, rdy);
  endtask

  task automatic idle_cycles(input int k, input bit rdy);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0, rdy);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy",  busy,          0);
    check("rst_done",  done,          0);
    check("rst_ovf",   overflow,      0);
    check("rst_data",  bus.out_data,  0);
    check("rst_row",   bus.out_row,   0);
    check("rst_col",   bus.out_col,   0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain_job();
    int guard = 0;
    while (m_state != 0 && guard < 3000) begin
      rand_data();
      drive(0, 0, 1, 0, 0, 1);
      guard++;
    end
    if (guard >= 3000) check("drain_timeout", 1, 0);
    idle_cycles(1, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    size  = '0;
    bus.push11 = 1'b0; bus.pushedge = 1'b0; bus.push22 = 1'b0;
    bus.out_ready = 1'b0;
    rand_data();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2, 0);

    // start with size 0 and pushes while idle are ignored
    drive(1, 17'd0, 0, 0, 1, 1);
    drive(1, 17'd1, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    idle_cycles(2, 1);

    // N=2 known-data tile
    drive(1, 17'd2, 0, 0, 0, 1);
    bus.c11 = 32'd1; bus.c12 = 32'd2; bus.c21 = 32'd3; bus.c22 = 32'd4;
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    idle_cycles(6, 1);

    // N=4, four tiles, free-flowing consumer
    drive(1, 17'd4, 0, 0, 0, 1);
    for (int t = 0; t < 4; t++) push_tile(1);
    idle_cycles(6, 1);

    // stalled consumer: fill to DEPTH, third tile push11 dropped
    drive(1, 17'd4, 0, 0, 0, 0);
    push_tile(0);
    push_tile(0);
    rand_data();
    drive(0, 0, 1, 0, 0, 0);
    idle_cycles(2, 0);
    async_reset();

    // occupancy 7, pop plus pushedge in the same cycle: both words dropped
    drive(1, 17'd4, 0, 0, 0, 0);
    push_tile(0);
    rand_data();
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    rand_data();
    drive(0, 0, 0, 1, 0, 1);
    idle_cycles(2, 0);
    async_reset();

    // reset mid-tile with three words queued, then a fresh N=2 job
    drive(1, 17'd2, 0, 0, 0, 0);
    rand_data();
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    async_reset();
    idle_cycles(2, 1);
    drive(1, 17'd2, 0, 0, 0, 1);
    push_tile(1);
    idle_cycles(6, 1);

    // randomized jobs, overlapping strobes and stray starts included
    for (int job = 0; job < 8; job++) begin
      drive(1, 17'($urandom_range(2, 7)), 0, 0, 0, $urandom_range(0, 1));
      for (int c = 0; c < 80; c++) begin
        int r;
        bit p11, pe, p22;
        r = $urandom_range(0, 9);
        p11 = (r <= 2);
        pe  = (r >= 3 && r <= 5);
        p22 = (r == 6 || r == 7);
        if (r == 9) begin
          p11 = $urandom_range(0, 1);
          pe  = $urandom_range(0, 1);
          p22 = $urandom_range(0, 1);
        end
        rand_data();
        drive($urandom_range(0, 9) == 0, 17'($urandom_range(0, 3)), p11, pe, p22,
              $urandom_range(0, 3) != 0);
      end
      drain_job();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DEPTH, 8, result FIFO depth in 32-bit words; power of two, minimum 4.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 start  input  1  begin a collection job; sampled only in IDLE.
REQ-005 size  input  17  square matrix dimension N, unsigned, sampled with start.
REQ-006 push11, pushedge, push22  input  1 each  tile-result strobes from the tensor-core sequencer.
REQ-007 c11, c12, c21, c22  input  32 each  signed accumulator outputs of the 2x2 array.
REQ-008 out_data  output  32  result word at FIFO head.
REQ-009 out_row, out_col  output  17 each  matrix coordinates of out_data.
REQ-010 out_valid  output  1  out_data, out_row and out_col are valid.
REQ-011 out_ready  input  1  consumer accepts the word this cycle.
REQ-012 done  output  1  one-cycle pulse after the final word of the job is accepted.
REQ-013 overflow  output  1  sticky: a push was dropped for lack of FIFO space.
REQ-014 busy  output  1  high in ACTIVE and DONE.

Function
REQ-015 FSM states: IDLE, ACTIVE, DONE.
REQ-016 IDLE -> ACTIVE on start with size >= 2.
- Entering ACTIVE: latch H = size[16:1] (odd N truncated down).
- Also clear tile and element counters and overflow.
- start with size < 2: ignored, remain IDLE.
REQ-017 ACTIVE -> DONE on the cycle the last word of tile H*H-1 is handshaked; DONE -> IDLE unconditionally next cycle; done = (state == DONE).
REQ-018 start outside IDLE is ignored; pushes outside ACTIVE are ignored and never set overflow.
REQ-019 Enqueue per strobe in ACTIVE:
- push11: c11 (1 word).
- pushedge: c12 then c21 (2 words, same cycle).
- push22: c22 (1 word).
- Tile output order is row-major: c11, c12, c21, c22.
REQ-020 Free space for the admission check is DEPTH minus occupancy at the start of the cycle; a same-cycle pop does not count as free space.
REQ-021 Space check failure: all words of that strobe are dropped (no partial write) and overflow sets, held until next start or reset.
REQ-022 Strobe overlap:
- Strobes are one-hot by protocol.
- If more than one is high, only the highest priority is serviced: push11 > pushedge > push22.
- overflow is not set for the others.
REQ-023 Occupancy update: +n written, -1 if out_valid && out_ready, in the same cycle; pointers wrap modulo DEPTH.
REQ-024 Latency: a word written at edge k is presented with out_valid at edge k+1 (registered FIFO, first-word fall-through after one cycle).
REQ-025 out_valid = (occupancy != 0) in ACTIVE; forced 0 in IDLE and DONE.
- out_data, out_row, out_col hold stable while out_valid && !out_ready.
REQ-026 Coordinates come from output-side counters advanced only on handshake:
- e: 2-bit element index, wraps 3 -> 0.
- tc: tile column; advances when e wraps; wraps at H-1 -> 0.
- tr: tile row; advances when tc wraps.
- out_row = 2*tr + e[1]; out_col = 2*tc + e[0].
REQ-027 Words never reorder; no data arithmetic; 32-bit values pass unmodified.

Reset
REQ-028 Assertion of reset asynchronously clears all of the following, mid-job included:
- state to IDLE;
- FIFO pointers and occupancy to 0;
- all counters to 0;
- out_valid, done, overflow, busy to 0;
- out_data, out_row, out_col to 0.
REQ-029 FIFO contents are discarded by reset; no word from before reset is ever presented after it.

Verification
REQ-030 N=2, out_ready=1, push11/pushedge/push22 on consecutive cycles with c11=1, c12=2, c21=3, c22=4:
- outputs 1@(0,0), 2@(0,1), 3@(1,0), 4@(1,1);
- done pulses once, cycle after word 4.
REQ-031 N=4, out_ready=1, four tiles:
- 16 words, tile coordinate order (0,0), (0,2), (2,0), (2,2) origins;
- done after word 16; overflow=0.
REQ-032 DEPTH=8, out_ready=0, two full tiles:
- occupancy 8, out_valid=1, out_data=first c11;
- third tile push11 -> dropped, overflow=1, occupancy stays 8.
REQ-033 Occupancy 7, out_ready=1, pushedge same cycle:
- both words dropped, overflow=1;
- one pop occurs, occupancy 6.
REQ-034 Reset asserted mid-tile with 3 words queued:
- out_valid=0 and state IDLE immediately, without waiting for clk;
- new start N=2 yields exactly 4 fresh words.
REQ-035 start with size=0, and push22 while IDLE:
- state stays IDLE, no word queued, overflow=0.
